// File: rtl/aes_shiftrows_pipe.sv
// AES / Rijndael ShiftRows and InvShiftRows stage for NB = 4, 6 or 8 columns.
// The row rotation is combinational on the input side. Results land in a
// 2-entry FIFO, so upstream never loses a state when downstream stalls.
// A wrapping counter records completed output handshakes.

// Rotates one row by a fixed byte count. Column 0 sits in the MS byte, so a
// left rotate (encrypt) moves bytes toward the MSB end.
module aes_row_rot #(
   parameter int NB    = 4,
   parameter int SHIFT = 0
) (
   input  logic [NB*8-1:0] row_i,
   input  logic            dec_i,
   output logic [NB*8-1:0] row_o
);
   localparam int W = NB * 8;
   localparam int K = SHIFT * 8;

   logic [2*W-1:0] dbl;

   // Both rotations are windows into the row concatenated with itself.
   assign dbl   = {row_i, row_i};
   assign row_o = dec_i ? dbl[K +: W] : dbl[W-K +: W];
endmodule

module aes_shiftrows_pipe #(
   parameter int NB    = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_decrypt,
   input  logic [NB*8-1:0]  in_row0,
   input  logic [NB*8-1:0]  in_row1,
   input  logic [NB*8-1:0]  in_row2,
   input  logic [NB*8-1:0]  in_row3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_decrypt,
   output logic [NB*8-1:0]  out_row0,
   output logic [NB*8-1:0]  out_row1,
   output logic [NB*8-1:0]  out_row2,
   output logic [NB*8-1:0]  out_row3,
   output logic [CNT_W-1:0] blk_count
);
   localparam int W = NB * 8;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $fatal(1, "aes_shiftrows_pipe: NB must be 4, 6 or 8");
   end

   // Rijndael row offsets: NB=8 uses 1/3/4, narrower blocks use 1/2/3.
   function automatic int shift_of(int r);
      if (r == 0) return 0;
      if (NB == 8) return (r == 1) ? 1 : (r == 2) ? 3 : 4;
      return r;
   endfunction

   typedef struct packed {
      logic                dec;
      logic [3:0][W-1:0]   rows;
   } ent_t;

   logic [3:0][W-1:0] in_rows;
   logic [3:0][W-1:0] rot_rows;
   ent_t              new_ent;

   ent_t [1:0]        mem_q, mem_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic [CNT_W-1:0]  blk_count_q, blk_count_d;
   logic              push, pop;

   assign in_rows = {in_row3, in_row2, in_row1, in_row0};

   for (genvar r = 0; r < 4; r++) begin : g_row
      aes_row_rot #(.NB(NB), .SHIFT(shift_of(r))) u_rot (
         .row_i (in_rows[r]),
         .dec_i (in_decrypt),
         .row_o (rot_rows[r])
      );
   end

   assign new_ent.dec  = in_decrypt;
   assign new_ent.rows = rot_rows;

   // Handshakes come only from registered occupancy, never from out_ready.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_decrypt = mem_q[rd_ptr_q].dec;
   assign out_row0    = mem_q[rd_ptr_q].rows[0];
   assign out_row1    = mem_q[rd_ptr_q].rows[1];
   assign out_row2    = mem_q[rd_ptr_q].rows[2];
   assign out_row3    = mem_q[rd_ptr_q].rows[3];
   assign blk_count   = blk_count_q;

   // Next-state for the FIFO pointers, occupancy, storage and block counter.
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      blk_count_d = blk_count_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_ent;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d    = ~rd_ptr_q;
         blk_count_d = blk_count_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards buffered states and clears the counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q       <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         blk_count_q <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         blk_count_q <= blk_count_d;
      end
   end
endmodule

// File: doc/aes_shiftrows_pipe.md
# aes_shiftrows_pipe

Registered, flow-controlled ShiftRows / InvShiftRows stage for the AES datapath, generalised to Rijndael block widths of 4, 6 or 8 columns. It sits between SubBytes and MixColumns in the round pipeline. The block accepts one state per handshake on a valid/ready interface, applies the row rotation selected per block by a decrypt flag, and holds results in a 2-entry output buffer so upstream stalls never drop data. It also counts completed blocks for round-sequencer bookkeeping.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8; any other value is an elaboration error.
- CNT_W, default 16: width of the completed-block counter.
- W (derived, not overridable): NB*8, the bit width of one row.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state present.
- in_ready  out  1  block can accept a state this cycle.
- in_decrypt  in  1  0 = ShiftRows (rotate left), 1 = InvShiftRows (rotate right); sampled with the data.
- in_row0..in_row3  in  W each  state rows; column 0 in the MS byte, column NB-1 in the LS byte.
- out_valid  out  1  output state present.
- out_ready  in  1  downstream accepts.
- out_decrypt  out  1  mode flag travelling with the state.
- out_row0..out_row3  out  W each  shifted rows.
- blk_count  out  CNT_W  number of output handshakes since reset; wraps modulo 2^CNT_W.

## Operation
- Shift offsets C1/C2/C3 for rows 1/2/3: 1/2/3 for NB=4 and NB=6; 1/3/4 for NB=8. Row 0 is never shifted.
- Encrypt: out row r, column c = in row r, column (c+Cr) mod NB, i.e. rotate left by Cr bytes.
- Decrypt: out row r, column c = in row r, column (c−Cr) mod NB, i.e. rotate right by Cr bytes.
- The transform is combinational on the input side. The transformed state and its flag are written into a 2-entry FIFO (two data registers, 1-bit write pointer, 1-bit read pointer, 2-bit occupancy count 0..2).
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2), decoded from registers only, with no combinational path from out_ready.
- out_valid = (count != 0). out_row*/out_decrypt are driven from the head entry and stay stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count 1. At count 2 no push is possible. At count 0 no pop is possible.
- blk_count increments by 1 on each pop. After 2^CNT_W−1 the next pop takes it to 0.
- Changing in_decrypt between blocks is allowed. Each entry keeps its own flag.

## Timing
- Reset (asynchronous assert, released synchronously by the surrounding reset logic): count=0, pointers=0, blk_count=0, out_valid=0, in_ready=1. Data registers and out_decrypt are cleared to 0.
- Latency: a state pushed at edge N appears with out_valid=1 after edge N, in the same cycle as the next edge. This is 1 cycle when the FIFO is empty at push.
- Throughput: 1 state per cycle when out_ready is held high. Steady-state count is 1.
- Backpressure: with out_ready low, two states are absorbed. in_ready falls after the second push edge. One pop raises in_ready after that pop edge.
- Reset mid-operation: all buffered states are discarded and blk_count returns to 0 immediately on rst assertion. No output handshake is reported for discarded entries.
- Input values are ignored when in_valid=0. Output data is don't-care when out_valid=0, but must still equal the reset value after reset.

## Test plan
- NB=4 encrypt: rows 0x00112233 / 0x01020304 / 0x05060708 / 0x090A0B0C, out_ready=1 → one cycle later out rows 0x00112233 / 0x02030401 / 0x07080506 / 0x0C090A0B, out_decrypt=0, blk_count=1.
- NB=4 decrypt of the previous outputs with in_decrypt=1 → original rows restored. Alternate the mode every cycle for 8 blocks → each output flag matches its input and throughput is 1 per cycle.
- NB=8 encrypt: row2 = 0x1011121314151617 → 0x1314151617101112; row3 = 0x0001020304050607 → 0x0405060700010203. Decrypt inverts both.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles → exactly 2 pushes, in_ready=0 from the third cycle. Release out_ready → outputs drain in order with no loss or duplication.
- Assert rst while count=2 → out_valid=0, in_ready=1 and blk_count=0 in the same cycle. The next pushed block emerges correctly with blk_count=1.
- Counter wrap with CNT_W=4: 17 pops → blk_count=1.
